wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_pkg.sv | 23 ++
 rtl/mux_2x1_32.sv | 20 ++
 rtl/wb_port_arbiter.sv | 99 +++++++++
 tb/tb_wb_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// wb_port_arbiter_pkg : shared processor definitions for the write-back port
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

    localparam int c_default_data_w = 32;
    localparam int c_default_addr_w = 5;
    localparam int c_default_cnt_w  = 16;

    // Register 0 is hardwired to zero; writes to it are swallowed.
    localparam int c_zero_reg_addr  = 0;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_idx_e;

endpackage

`default_nettype wire

// File: rtl/mux_2x1_32.sv
// ============================================================================
// mux_2x1_32 : 2:1 data multiplexer (32-bit by default)
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_2x1_32 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in1 : in0;

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : round-robin arbiter for the register-file write port
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DATA_W = c_default_data_w,
    parameter int ADDR_W = c_default_addr_w,
    parameter int CNT_W  = c_default_cnt_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  gnt_cnt
);

    grant_idx_e        r_last;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [CNT_W-1:0]  r_gnt_cnt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // Grants are gated by reset so nothing leaks out while it is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset && !stall) begin
            if (req0 && req1) begin
                w_gnt0 = (r_last == GRANT_REQ1);
                w_gnt1 = (r_last == GRANT_REQ0);
            end else begin
                w_gnt0 = req0;
                w_gnt1 = req1;
            end
        end
    end

    assign w_grant = w_gnt0 | w_gnt1;
    assign w_addr  = w_gnt1 ? addr1 : addr0;

    mux_2x1_32 #(
        .WIDTH (DATA_W)
    ) u_data_mux (
        .sel (w_gnt1),
        .in0 (data0),
        .in1 (data1),
        .out (w_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last    <= GRANT_REQ1;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_gnt_cnt <= '0;
        end else if (w_grant) begin
            r_last    <= w_gnt1 ? GRANT_REQ1 : GRANT_REQ0;
            r_wr_en   <= (w_addr != ADDR_W'(c_zero_reg_addr));
            r_wr_addr <= w_addr;
            r_wr_data <= w_data;
            r_gnt_cnt <= r_gnt_cnt + 1'b1;
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign sel     = w_gnt1;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign gnt_cnt = r_gnt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : scoreboard bench for wb_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          req0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] data0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data1;
    logic          gnt0;
    logic          gnt1;
    logic          sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] gnt_cnt;

    wb_port_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .CNT_W  (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .req0    (req0),
        .addr0   (addr0),
        .data0   (data0),
        .req1    (req1),
        .addr1   (addr1),
        .data1   (data1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt_cnt (gnt_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected write-port effect of each grant, in order.
    typedef struct {
        bit            en;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           sbq[$];
    int            m_last = 1;
    bit            m_g0   = 1'b0;
    bit            m_g1   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    int unsigned   m_cnt  = 0;

    // Grant checker: decides the winner from the round-robin rule just before each edge.
    always @(negedge clk) begin : grant_chk
        int  w;
        wr_t it;
        w = -1;
        if (!reset && !stall) begin
            if (req0 && req1) w = (m_last == 0) ? 1 : 0;
            else if (req0)    w = 0;
            else if (req1)    w = 1;
        end
        m_g0 = (w == 0);
        m_g1 = (w == 1);
        check("gnt0", gnt0, m_g0);
        check("gnt1", gnt1, m_g1);
        check("sel",  sel,  m_g1);
        if (w >= 0) begin
            it.a   = (w == 1) ? addr1 : addr0;
            it.d   = (w == 1) ? data1 : data0;
            it.en  = (it.a != 0);
            sbq.push_back(it);
            m_last = w;
        end
    end

    // Monitor: after every edge, consume the grant (if any) issued at that edge.
    always @(posedge clk) begin : wr_mon
        wr_t it;
        bit  exp_en;
        #2;
        exp_en = 1'b0;
        if (sbq.size() > 0) begin
            it     = sbq.pop_front();
            exp_en = it.en;
            m_addr = it.a;
            m_data = it.d;
            m_cnt  = (m_cnt + 1) % (1 << CW);
        end
        check("wr_en",   wr_en,   exp_en);
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_data);
        check("gnt_cnt", gnt_cnt, m_cnt);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset with both requests high to show grants stay forced low.
    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        m_last = 1;
        m_addr = '0;
        m_data = '0;
        m_cnt  = 0;
        m_g0   = 1'b0;
        m_g1   = 1'b0;
        req0   = 1'b1;
        req1   = 1'b1;
        stall  = 1'b0;
        #1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_gnt1", gnt1, 1'b0);
        check("rst_sel",  sel,  1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        req0  = 1'b0;
        req1  = 1'b0;
        reset = 1'b0;
        cyc();
        check("rst_wr_en",   wr_en,   1'b0);
        check("rst_wr_addr", wr_addr, '0);
        check("rst_wr_data", wr_data, '0);
        check("rst_gnt_cnt", gnt_cnt, '0);
    endtask

    int  pat_g1[4] = '{0, 1, 0, 1};
    int  pat_a[4]  = '{1, 2, 1, 2};

    initial begin
        reset = 1'b1; stall = 1'b0;
        req0 = 1'b0; addr0 = '0; data0 = '0;
        req1 = 1'b0; addr1 = '0; data1 = '0;
        do_reset();

        // Single requester, same-cycle grant, one-cycle write latency.
        req0 = 1'b1; addr0 = 5; data0 = 32'hDEADBEEF;
        @(negedge clk); #1;
        check("d36_gnt0", gnt0, 1'b1);
        cyc();
        req0 = 1'b0;
        check("d36_wr_en", wr_en, 1'b1);
        check("d36_wr_addr", wr_addr, 5);
        check("d36_wr_data", wr_data, 32'hDEADBEEF);
        check("d36_cnt", gnt_cnt, 1);

        // Tie alternation from reset.
        do_reset();
        req0 = 1'b1; addr0 = 1; data0 = 32'h1111;
        req1 = 1'b1; addr1 = 2; data1 = 32'h2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check("d37_gnt1", gnt1, pat_g1[i][0]);
            cyc();
            check("d37_wr_addr", wr_addr, pat_a[i]);
        end
        req0 = 1'b0; req1 = 1'b0;
        check("d37_cnt", gnt_cnt, 4);

        // Grant to register 0 completes without a write.
        req1 = 1'b1; addr1 = 0; data1 = 32'h12345678;
        @(negedge clk); #1;
        check("d38_gnt1", gnt1, 1'b1);
        check("d38_sel", sel, 1'b1);
        cyc();
        req1 = 1'b0;
        check("d38_wr_en", wr_en, 1'b0);
        check("d38_cnt", gnt_cnt, 5);

        // Stall blocks grants; requester 0 wins when it drops.
        req0 = 1'b1; addr0 = 3; req1 = 1'b1; addr1 = 4; stall = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("d39_stall_gnt", {gnt0, gnt1}, 2'b00);
            cyc();
            check("d39_stall_wr_en", wr_en, 1'b0);
        end
        stall = 1'b0;
        @(negedge clk); #1;
        check("d39_gnt0", gnt0, 1'b1);
        cyc();
        req0 = 1'b0;
        @(negedge clk); #1;
        check("d39_gnt1", gnt1, 1'b1);
        cyc();
        req1 = 1'b0;

        // Reset between a grant and its edge discards it.
        req0 = 1'b1; addr0 = 7; data0 = 32'hCAFEF00D;
        @(negedge clk); #1;
        check("d40_gnt0", gnt0, 1'b1);
        do_reset();
        check("d40_wr_en", wr_en, 1'b0);

        // Counter wrap.
        req0 = 1'b1; addr0 = 3; data0 = 32'hA5A5A5A5;
        req1 = 1'b1; addr1 = 4; data1 = 32'h5A5A5A5A;
        repeat (65535) cyc();
        check("d41_cnt_max", gnt_cnt, 16'hFFFF);
        cyc();
        check("d41_cnt_wrap", gnt_cnt, 16'h0000);
        req0 = 1'b0; req1 = 1'b0;

        // Randomized traffic honouring the hold-until-granted handshake.
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                if (m_g0 || !req0) begin
                    req0  = ($urandom_range(0, 3) != 0);
                    addr0 = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
                    data0 = $urandom;
                end
                if (m_g1 || !req1) begin
                    req1  = ($urandom_range(0, 3) != 0);
                    addr1 = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom);
                    data1 = $urandom;
                end
                stall = ($urandom_range(0, 3) == 0);
            end
        end
        req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
